cla_pipe_adder: RTL and testbench
=================================

CLA_PIPE_ADDER -- requirements
Module: cla_pipe_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving operand and sum width in bits (WIDTH >= 2).
REQ-002 The block SHALL have parameter GROUP, default 4, giving lookahead group size in bits; WIDTH SHALL be a multiple of GROUP.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 in_valid  in  1  operand set on a, b, cin, op is valid.
REQ-006 in_ready  out  1  block accepts an operand set this cycle.
REQ-007 a, b  in  WIDTH each  operands.
REQ-008 cin  in  1  carry-in for add and accumulate.
REQ-009 op  in  2  00 add, 01 subtract, 10 accumulate, 11 clear accumulator.
REQ-010 out_valid  out  1  result on sum, cout, ovf is valid.
REQ-011 out_ready  in  1  downstream accepts the result.
REQ-012 sum  out  WIDTH  result.
REQ-013 cout  out  1  carry out of bit WIDTH-1.
REQ-014 ovf  out  1  two's-complement signed overflow.

Function
REQ-015 Accept SHALL occur when in_valid and in_ready are both high on a rising edge; output transfer SHALL occur when out_valid and out_ready are both high.
REQ-016 Pipeline SHALL have two register stages:
- S1 registers per-group generate/propagate, the operand sets, effective carry-in and op.
- S2 is the output register, loaded from group-carry lookahead plus in-group ripple on S1 contents.
REQ-017 Latency SHALL be exactly 2 cycles from accept to out_valid when unstalled.
REQ-018 stall = out_valid & ~out_ready; in_ready SHALL equal ~stall.
- While stall is high, S1 and S2 SHALL hold.
- Otherwise both stages advance; an empty S1 SHALL load a bubble into S2, making out_valid low.
REQ-019 Throughput SHALL be one result per cycle while out_ready is high; results SHALL leave in accept order with no loss or duplication.
REQ-020 op=00: {cout,sum} SHALL equal a + b + cin computed over WIDTH+1 bits.
REQ-021 op=01: the sum SHALL be a + ~b + 1; cin SHALL be ignored; cout=1 SHALL mean no borrow.
REQ-022 op=10: the sum SHALL be acc + a + cin, with b ignored; acc SHALL load the sum on the same edge that S2 loads this result.
- Back-to-back accumulates SHALL therefore chain with no hazard.
REQ-023 op=11: acc SHALL be set to 0, and the result SHALL be sum=0, cout=0, ovf=0.
REQ-024 acc SHALL be WIDTH bits wide; it SHALL wrap modulo 2^WIDTH and SHALL be invisible except through results.
REQ-025 ovf SHALL be 1 iff the two effective operands have equal sign bits and the sum sign bit differs from them; otherwise ovf SHALL be 0.
REQ-026 A stalled S1 entry that is an accumulate SHALL NOT update acc until it loads into S2.
REQ-027 Carry between groups SHALL use lookahead: Cg+1 = Gg | Pg·Cg, using no ripple across group boundaries.
- Results SHALL be bit-identical to a behavioural adder for all WIDTH/GROUP combinations.

Reset
REQ-028 rst high SHALL asynchronously clear S1 valid, out_valid, sum, cout, ovf and acc to 0.
REQ-029 While rst is high, in_ready SHALL be 1; no accept SHALL take effect.
REQ-030 Reset mid-operation SHALL discard all in-flight operand sets; the first result after release SHALL come from the first post-reset accept.

Verification
REQ-031 The bench SHALL cover, with WIDTH=16 and GROUP=4, add a=0xFFFF, b=0x0001, cin=0.
- Expected result two cycles after accept: sum=0x0000, cout=1, ovf=0.
REQ-032 The bench SHALL cover subtract a=0x8000, b=0x0001.
- Expected result: sum=0x7FFF, cout=1, ovf=1.
- Also a=0x0003, b=0x0005: sum=0xFFFE, cout=0, ovf=0.
REQ-033 The bench SHALL cover the sequence clear; accumulate a=5, cin=0; accumulate a=7, cin=1; all accepted back-to-back.
- Expected results in order: 0, 5, 13.
REQ-034 The bench SHALL cover backpressure with out_ready low for 4 cycles while issuing add a=1,2,3 (b=0).
- in_ready SHALL drop once the pipe is full.
- On out_ready high, results 1, 2, 3 SHALL appear in order on consecutive cycles.
REQ-035 The bench SHALL assert rst for 1 cycle with two operand sets in flight and acc=0x0010.
- All outputs SHALL be 0 and acc SHALL be 0.
- The next accumulate a=1 SHALL yield sum=1.
REQ-036 The bench SHALL run an exhaustive sweep at WIDTH=3, GROUP=3 over all 128 (a, b, cin) add combinations.
- Each {cout,sum} SHALL match a behavioural a+b+cin.
- The bench SHALL print PASS or FAIL per vector, and the test SHALL fail on any mismatch.

Source files
------------

// File: rtl/cla_pipe_adder_if.sv
// ----------------------------------------------------------------------------
// cla_pipe_adder_if
// Operand/result handshake bundle for cla_pipe_adder.
//   in_valid/in_ready   : operand-set handshake (a, b, cin, op)
//   out_valid/out_ready : result handshake (sum, cout, ovf)
// Modports:
//   master : the side that issues operands and consumes results
//   slave  : the adder itself
// ----------------------------------------------------------------------------
interface cla_pipe_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [1:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, op, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, op, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/cla_pipe_adder.sv
// ----------------------------------------------------------------------------
// cla_pipe_adder
// Two-stage pipelined carry-lookahead adder with add / subtract /
// accumulate / clear-accumulator operations and valid/ready flow control.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : cla_pipe_adder_if.slave (operands in, result out)
// Stage 1 registers the effective operands, carry-in, op and the bit- and
// group-level generate/propagate terms. Stage 2 (output register) is loaded
// from group-carry lookahead plus in-group ripple on the stage-1 contents.
// ----------------------------------------------------------------------------
module cla_pipe_adder #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic            clk,
    input  logic            rst,
    cla_pipe_adder_if.slave bus
);
    localparam int NG = WIDTH / GROUP;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ACC = 2'b10,
        OP_CLR = 2'b11
    } op_e;

    typedef struct packed {
        logic [NG-1:0] g;
        logic [NG-1:0] p;
    } grp_t;

    // Group generate/propagate from bit-level terms (p is the XOR propagate).
    function automatic grp_t group_gp(input logic [WIDTH-1:0] g, input logic [WIDTH-1:0] p);
        grp_t r;
        logic gg;
        logic pp;
        r = '0;
        for (int k = 0; k < NG; k++) begin
            gg = 1'b0;
            pp = 1'b1;
            for (int i = 0; i < GROUP; i++) begin
                gg = g[k*GROUP+i] | (p[k*GROUP+i] & gg);
                pp = pp & p[k*GROUP+i];
            end
            r.g[k] = gg;
            r.p[k] = pp;
        end
        return r;
    endfunction

    // Handshake
    logic stall;
    logic accept;
    logic out_valid_q;

    assign stall        = out_valid_q & ~bus.out_ready;
    assign bus.in_ready = ~stall;
    assign accept       = bus.in_valid & bus.in_ready;

    // ---------------- Stage 1: effective operands ----------------
    logic [WIDTH-1:0] s1_x_d, s1_y_d;
    logic             s1_c_d;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        s1_x_d = bus.a;
        s1_y_d = bus.b;
        s1_c_d = bus.cin;
        case (bus.op)
            OP_SUB: begin
                s1_y_d = ~bus.b;
                s1_c_d = 1'b1;
            end
            OP_ACC: begin
                // The accumulator operand is substituted in stage 2, where acc is
                // guaranteed current even for back-to-back accumulates.
                s1_x_d = '0;
                s1_y_d = bus.a;
            end
            OP_CLR: begin
                s1_x_d = '0;
                s1_y_d = '0;
                s1_c_d = 1'b0;
            end
            default: ;
        endcase
    end

    logic             s1_valid_q;
    logic [WIDTH-1:0] s1_x_q, s1_y_q, s1_g_q, s1_p_q;
    logic             s1_c_q;
    op_e              s1_op_q;
    grp_t             s1_gp_q;

    // NOTE: the stage-1 datapath has no reset; s1_valid_q alone qualifies it.
    always_ff @(posedge clk) begin
        if (!stall) begin
            s1_x_q  <= s1_x_d;
            s1_y_q  <= s1_y_d;
            s1_c_q  <= s1_c_d;
            s1_op_q <= op_e'(bus.op);
            s1_g_q  <= s1_x_d & s1_y_d;
            s1_p_q  <= s1_x_d ^ s1_y_d;
            s1_gp_q <= group_gp(s1_x_d & s1_y_d, s1_x_d ^ s1_y_d);
        end
    end

    // ---------------- Stage 2: lookahead + ripple ----------------
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] x2, g2, p2;
    grp_t             gp2;
    logic [NG:0]      gc;
    logic             rc;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d, ovf_d;

    always_comb begin
        x2  = s1_x_q;
        g2  = s1_g_q;
        p2  = s1_p_q;
        gp2 = s1_gp_q;
        if (s1_op_q == OP_ACC) begin
            x2  = acc_q;
            g2  = acc_q & s1_y_q;
            p2  = acc_q ^ s1_y_q;
            gp2 = group_gp(acc_q & s1_y_q, acc_q ^ s1_y_q);
        end

        // Carry into each group comes from group G/P only.
        gc    = '0;
        gc[0] = s1_c_q;
        for (int k = 0; k < NG; k++) begin
            gc[k+1] = gp2.g[k] | (gp2.p[k] & gc[k]);
        end

        // Ripple within each group, seeded by its lookahead carry.
        sum_d = '0;
        rc    = 1'b0;
        for (int k = 0; k < NG; k++) begin
            rc = gc[k];
            for (int i = 0; i < GROUP; i++) begin
                sum_d[k*GROUP+i] = p2[k*GROUP+i] ^ rc;
                rc = g2[k*GROUP+i] | (p2[k*GROUP+i] & rc);
            end
        end

        cout_d = gc[NG];
        ovf_d  = (x2[WIDTH-1] == s1_y_q[WIDTH-1]) & (sum_d[WIDTH-1] != x2[WIDTH-1]);

        if (s1_op_q == OP_CLR) begin
            sum_d  = '0;
            cout_d = 1'b0;
            ovf_d  = 1'b0;
        end
    end

    logic [WIDTH-1:0] sum_q;
    logic             cout_q, ovf_q;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            acc_q       <= '0;
        end else if (!stall) begin
            s1_valid_q  <= accept;
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
                ovf_q  <= ovf_d;
                // acc moves on the same edge its result enters the output register.
                if (s1_op_q == OP_ACC || s1_op_q == OP_CLR) begin
                    acc_q <= sum_d;
                end
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_cla_pipe_adder.sv
// ----------------------------------------------------------------------------
// tb_cla_pipe_adder
// Self-checking bench for cla_pipe_adder: a 16/4 instance for directed and
// randomized traffic, and a 3/3 instance for an exhaustive add sweep.
// Expected results come from an arithmetic reference model.
// ----------------------------------------------------------------------------
module tb_cla_pipe_adder;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ACC = 2'b10;
    localparam logic [1:0] OP_CLR = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cla_pipe_adder_if #(.WIDTH(16)) m ();
    cla_pipe_adder_if #(.WIDTH(3))  s ();

    cla_pipe_adder #(.WIDTH(16), .GROUP(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (m)
    );

    cla_pipe_adder #(.WIDTH(3), .GROUP(3)) dut_small (
        .clk (clk),
        .rst (rst),
        .bus (s)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        cout;
        logic        ovf;
        logic [15:0] sum;
    } res_t;

    logic [15:0] m_acc = '0;

    // Reference model: plain integer arithmetic; overflow is "true signed
    // result out of 16-bit range".
    function automatic res_t model(input logic [1:0] op, input logic [15:0] a,
                                   input logic [15:0] b, input logic cin);
        int ua, ub, uc, uacc, sa, sb, sacc, ut, st;
        res_t r;
        ua   = a;
        ub   = b;
        uc   = cin;
        uacc = m_acc;
        sa   = $signed(a);
        sb   = $signed(b);
        sacc = $signed(m_acc);
        r    = '0;
        ut   = 0;
        st   = 0;
        case (op)
            OP_ADD: begin
                ut = ua + ub + uc;
                st = sa + sb + uc;
                r.cout = ut[16];
            end
            OP_SUB: begin
                ut = ua - ub;
                st = sa - sb;
                r.cout = (ua >= ub);
            end
            OP_ACC: begin
                ut = uacc + ua + uc;
                st = sacc + sa + uc;
                r.cout = ut[16];
                m_acc = ut[15:0];
            end
            default: begin
                m_acc = '0;
            end
        endcase
        if (op != OP_CLR) begin
            r.sum = ut[15:0];
            r.ovf = (st > 32767) || (st < -32768);
        end
        return r;
    endfunction

    task automatic drive(input logic v, input logic [1:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic cin);
        m.in_valid = v;
        m.op       = op;
        m.a        = a;
        m.b        = b;
        m.cin      = cin;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, OP_ADD, 16'h0, 16'h0, 1'b0);
        m.out_ready = 1'b1;
        s.in_valid  = 1'b0;
        s.op        = 2'b00;
        s.a         = '0;
        s.b         = '0;
        s.cin       = 1'b0;
        s.out_ready = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({m.out_valid, m.cout, m.ovf, m.sum} !== 19'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", {m.out_valid, m.cout, m.ovf, m.sum});
        end
        checks++;
        if (m.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b expected 1", m.in_ready);
        end
        rst   = 1'b0;
        m_acc = '0;
        tick();
    endtask

    task automatic test_add_boundary();
        res_t r;
        drive(1'b1, OP_ADD, 16'hFFFF, 16'h0001, 1'b0);
        r = model(OP_ADD, 16'hFFFF, 16'h0001, 1'b0);
        tick();
        drive(1'b0, OP_ADD, 16'h0, 16'h0, 1'b0);
        checks++;
        if (m.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_latency_early: out_valid %b expected 0", m.out_valid);
        end
        tick();
        checks++;
        if ({m.out_valid, m.cout, m.ovf, m.sum} !== {1'b1, 1'b1, 1'b0, 16'h0000}) begin
            errors++;
            $display("FAIL add_ffff_plus_1: got %h expected %h",
                     {m.out_valid, m.cout, m.ovf, m.sum}, {1'b1, 1'b1, 1'b0, 16'h0000});
        end
        checks++;
        if ({m.cout, m.ovf, m.sum} !== r) begin
            errors++;
            $display("FAIL add_model: got %h expected %h", {m.cout, m.ovf, m.sum}, r);
        end
        tick();
        checks++;
        if (m.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_bubble: out_valid %b expected 0", m.out_valid);
        end
    endtask

    task automatic test_subtract();
        drive(1'b1, OP_SUB, 16'h8000, 16'h0001, 1'b0);
        void'(model(OP_SUB, 16'h8000, 16'h0001, 1'b0));
        tick();
        drive(1'b1, OP_SUB, 16'h0003, 16'h0005, 1'b1);
        void'(model(OP_SUB, 16'h0003, 16'h0005, 1'b1));
        tick();
        drive(1'b0, OP_ADD, 16'h0, 16'h0, 1'b0);
        checks++;
        if ({m.out_valid, m.cout, m.ovf, m.sum} !== {1'b1, 1'b1, 1'b1, 16'h7FFF}) begin
            errors++;
            $display("FAIL sub_8000_1: got %h expected %h",
                     {m.out_valid, m.cout, m.ovf, m.sum}, {1'b1, 1'b1, 1'b1, 16'h7FFF});
        end
        tick();
        checks++;
        if ({m.out_valid, m.cout, m.ovf, m.sum} !== {1'b1, 1'b0, 1'b0, 16'hFFFE}) begin
            errors++;
            $display("FAIL sub_3_5: got %h expected %h",
                     {m.out_valid, m.cout, m.ovf, m.sum}, {1'b1, 1'b0, 1'b0, 16'hFFFE});
        end
        tick();
    endtask

    task automatic test_accumulate();
        drive(1'b1, OP_CLR, 16'h1234, 16'h5678, 1'b1);
        void'(model(OP_CLR, 16'h1234, 16'h5678, 1'b1));
        tick();
        drive(1'b1, OP_ACC, 16'd5, 16'hAAAA, 1'b0);
        void'(model(OP_ACC, 16'd5, 16'hAAAA, 1'b0));
        tick();
        checks++;
        if ({m.out_valid, m.cout, m.ovf, m.sum} !== {1'b1, 1'b0, 1'b0, 16'd0}) begin
            errors++;
            $display("FAIL acc_clear: got %h expected %h",
                     {m.out_valid, m.cout, m.ovf, m.sum}, {1'b1, 1'b0, 1'b0, 16'd0});
        end
        drive(1'b1, OP_ACC, 16'd7, 16'h5555, 1'b1);
        void'(model(OP_ACC, 16'd7, 16'h5555, 1'b1));
        tick();
        drive(1'b0, OP_ADD, 16'h0, 16'h0, 1'b0);
        checks++;
        if ({m.out_valid, m.cout, m.ovf, m.sum} !== {1'b1, 1'b0, 1'b0, 16'd5}) begin
            errors++;
            $display("FAIL acc_5: got %h expected %h",
                     {m.out_valid, m.cout, m.ovf, m.sum}, {1'b1, 1'b0, 1'b0, 16'd5});
        end
        tick();
        checks++;
        if ({m.out_valid, m.cout, m.ovf, m.sum} !== {1'b1, 1'b0, 1'b0, 16'd13}) begin
            errors++;
            $display("FAIL acc_13: got %h expected %h",
                     {m.out_valid, m.cout, m.ovf, m.sum}, {1'b1, 1'b0, 1'b0, 16'd13});
        end
        tick();
    endtask

    task automatic test_backpressure();
        m.out_ready = 1'b0;
        drive(1'b1, OP_ADD, 16'd1, 16'd0, 1'b0);
        tick();
        drive(1'b1, OP_ADD, 16'd2, 16'd0, 1'b0);
        tick();
        // Result 1 is held in the output register, 2 sits in stage 1.
        drive(1'b1, OP_ADD, 16'd3, 16'd0, 1'b0);
        checks++;
        if (m.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_in_ready_full: got %b expected 0", m.in_ready);
        end
        tick();
        tick();
        checks++;
        if ({m.in_ready, m.out_valid, m.sum} !== {1'b0, 1'b1, 16'd1}) begin
            errors++;
            $display("FAIL bp_hold: got %h expected %h", {m.in_ready, m.out_valid, m.sum},
                     {1'b0, 1'b1, 16'd1});
        end
        m.out_ready = 1'b1;
        #1;
        checks++;
        if ({m.in_ready, m.out_valid, m.sum} !== {1'b1, 1'b1, 16'd1}) begin
            errors++;
            $display("FAIL bp_release_1: got %h expected %h", {m.in_ready, m.out_valid, m.sum},
                     {1'b1, 1'b1, 16'd1});
        end
        tick();
        drive(1'b0, OP_ADD, 16'h0, 16'h0, 1'b0);
        checks++;
        if ({m.out_valid, m.sum} !== {1'b1, 16'd2}) begin
            errors++;
            $display("FAIL bp_release_2: got %h expected %h", {m.out_valid, m.sum}, {1'b1, 16'd2});
        end
        tick();
        checks++;
        if ({m.out_valid, m.sum} !== {1'b1, 16'd3}) begin
            errors++;
            $display("FAIL bp_release_3: got %h expected %h", {m.out_valid, m.sum}, {1'b1, 16'd3});
        end
        tick();
        checks++;
        if (m.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drained: out_valid %b expected 0", m.out_valid);
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, OP_CLR, 16'h0, 16'h0, 1'b0);
        tick();
        drive(1'b1, OP_ACC, 16'h0010, 16'h0, 1'b0);
        tick();
        drive(1'b0, OP_ADD, 16'h0, 16'h0, 1'b0);
        tick();
        tick();
        // acc now holds 0x0010; put two operand sets in flight.
        drive(1'b1, OP_ADD, 16'h1234, 16'h1111, 1'b0);
        tick();
        drive(1'b1, OP_ACC, 16'h0005, 16'h0, 1'b0);
        tick();
        drive(1'b1, OP_ACC, 16'h0007, 16'h0, 1'b1);
        rst = 1'b1;
        #1;
        checks++;
        if ({m.in_ready, m.out_valid, m.cout, m.ovf, m.sum} !== {1'b1, 19'h0}) begin
            errors++;
            $display("FAIL rst_async: got %h expected %h",
                     {m.in_ready, m.out_valid, m.cout, m.ovf, m.sum}, {1'b1, 19'h0});
        end
        tick();
        checks++;
        if ({m.in_ready, m.out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL rst_held: got %b expected 10", {m.in_ready, m.out_valid});
        end
        drive(1'b0, OP_ADD, 16'h0, 16'h0, 1'b0);
        rst   = 1'b0;
        m_acc = '0;
        tick();
        checks++;
        if (m.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_discard: out_valid %b expected 0", m.out_valid);
        end
        drive(1'b1, OP_ACC, 16'd1, 16'h0, 1'b0);
        void'(model(OP_ACC, 16'd1, 16'h0, 1'b0));
        tick();
        drive(1'b0, OP_ADD, 16'h0, 16'h0, 1'b0);
        tick();
        checks++;
        if ({m.out_valid, m.cout, m.ovf, m.sum} !== {1'b1, 1'b0, 1'b0, 16'd1}) begin
            errors++;
            $display("FAIL rst_then_acc: got %h expected %h",
                     {m.out_valid, m.cout, m.ovf, m.sum}, {1'b1, 1'b0, 1'b0, 16'd1});
        end
        tick();
    endtask

    task automatic test_random(input int n);
        res_t q[$];
        res_t e;
        int   sent, got, cyc;
        logic acc_now;
        logic [1:0] rop;
        sent = 0;
        got  = 0;
        cyc  = 0;
        drive(1'b0, OP_ADD, 16'h0, 16'h0, 1'b0);
        while (got < n && cyc < 20000) begin
            m.out_ready = ($urandom_range(0, 3) != 0);
            if (!m.in_valid && sent < n && $urandom_range(0, 4) != 0) begin
                rop = ($urandom_range(0, 15) == 0) ? OP_CLR : 2'($urandom_range(0, 2));
                drive(1'b1, rop, 16'($urandom()), 16'($urandom()), 1'($urandom()));
            end
            #1;
            checks++;
            if (m.in_ready !== !(m.out_valid && !m.out_ready)) begin
                errors++;
                $display("FAIL rnd_in_ready: got %b out_valid %b out_ready %b",
                         m.in_ready, m.out_valid, m.out_ready);
            end
            if (m.out_valid && m.out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL rnd_extra_result: got %h expected none", {m.cout, m.ovf, m.sum});
                end else begin
                    e = q.pop_front();
                    if ({m.cout, m.ovf, m.sum} !== e) begin
                        errors++;
                        $display("FAIL rnd_result %0d: got %h expected %h", got,
                                 {m.cout, m.ovf, m.sum}, e);
                    end
                end
                got++;
            end
            acc_now = m.in_valid && m.in_ready;
            if (acc_now) begin
                q.push_back(model(m.op, m.a, m.b, m.cin));
                sent++;
            end
            tick();
            if (acc_now) m.in_valid = 1'b0;
            cyc++;
        end
        checks++;
        if (got < n) begin
            errors++;
            $display("FAIL rnd_timeout: got %0d results expected %0d", got, n);
        end
        m.out_ready = 1'b1;
        drive(1'b0, OP_ADD, 16'h0, 16'h0, 1'b0);
        tick();
    endtask

    task automatic test_sweep_small();
        int j, e;
        logic [3:0] e4;
        s.out_ready = 1'b1;
        for (int i = 0; i <= 128; i++) begin
            if (i < 128) begin
                s.in_valid = 1'b1;
                s.op       = OP_ADD;
                s.a        = i[2:0];
                s.b        = i[5:3];
                s.cin      = i[6];
            end else begin
                s.in_valid = 1'b0;
            end
            tick();
            if (i >= 1) begin
                j  = i - 1;
                e  = (j & 7) + ((j >> 3) & 7) + ((j >> 6) & 1);
                e4 = 4'(e);
                checks++;
                if ({s.out_valid, s.cout, s.sum} !== {1'b1, e4}) begin
                    errors++;
                    $display("FAIL sweep vector %0d: got %b expected %b", j,
                             {s.out_valid, s.cout, s.sum}, {1'b1, e4});
                end else begin
                    $display("PASS sweep vector %0d: {cout,sum}=%b", j, e4);
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add_boundary();
        test_subtract();
        test_accumulate();
        test_backpressure();
        test_reset_mid();
        test_random(400);
        test_sweep_small();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
